// File: rtl/alu_share_arb_if.sv
// Bundle of the two requester handshakes, their response channels and the
// shared ALU bus. The arbiter connects through the slave modport. The
// requesters and the ALU connect through the master modport.
interface alu_share_arb_if #(
    parameter int XLEN = 32
);
    // Requester 0 (execute stage)
    logic            i_req0_valid;
    logic            o_req0_ready;
    logic [XLEN-1:0] i_req0_op1;
    logic [XLEN-1:0] i_req0_op2;
    logic [2:0]      i_req0_opsel;
    logic            i_req0_sub;
    logic            i_req0_unsigned;
    logic            i_req0_arith;
    logic            o_rsp0_valid;
    logic            i_rsp0_ready;
    logic [XLEN-1:0] o_rsp0_result;
    logic            o_rsp0_eq;
    logic            o_rsp0_lt;

    // Requester 1 (address/branch helper)
    logic            i_req1_valid;
    logic            o_req1_ready;
    logic [XLEN-1:0] i_req1_op1;
    logic [XLEN-1:0] i_req1_op2;
    logic [2:0]      i_req1_opsel;
    logic            i_req1_sub;
    logic            i_req1_unsigned;
    logic            i_req1_arith;
    logic            o_rsp1_valid;
    logic            i_rsp1_ready;
    logic [XLEN-1:0] o_rsp1_result;
    logic            o_rsp1_eq;
    logic            o_rsp1_lt;

    // Shared combinational ALU
    logic [XLEN-1:0] o_alu_op1;
    logic [XLEN-1:0] o_alu_op2;
    logic [2:0]      o_alu_opsel;
    logic            o_alu_sub;
    logic            o_alu_unsigned;
    logic            o_alu_arith;
    logic [XLEN-1:0] i_alu_result;
    logic            i_alu_eq;
    logic            i_alu_lt;

    modport slave (
        input  i_req0_valid, i_req0_op1, i_req0_op2, i_req0_opsel,
               i_req0_sub, i_req0_unsigned, i_req0_arith, i_rsp0_ready,
        input  i_req1_valid, i_req1_op1, i_req1_op2, i_req1_opsel,
               i_req1_sub, i_req1_unsigned, i_req1_arith, i_rsp1_ready,
        input  i_alu_result, i_alu_eq, i_alu_lt,
        output o_req0_ready, o_rsp0_valid, o_rsp0_result, o_rsp0_eq, o_rsp0_lt,
        output o_req1_ready, o_rsp1_valid, o_rsp1_result, o_rsp1_eq, o_rsp1_lt,
        output o_alu_op1, o_alu_op2, o_alu_opsel, o_alu_sub,
               o_alu_unsigned, o_alu_arith
    );

    modport master (
        output i_req0_valid, i_req0_op1, i_req0_op2, i_req0_opsel,
               i_req0_sub, i_req0_unsigned, i_req0_arith, i_rsp0_ready,
        output i_req1_valid, i_req1_op1, i_req1_op2, i_req1_opsel,
               i_req1_sub, i_req1_unsigned, i_req1_arith, i_rsp1_ready,
        output i_alu_result, i_alu_eq, i_alu_lt,
        input  o_req0_ready, o_rsp0_valid, o_rsp0_result, o_rsp0_eq, o_rsp0_lt,
        input  o_req1_ready, o_rsp1_valid, o_rsp1_result, o_rsp1_eq, o_rsp1_lt,
        input  o_alu_op1, o_alu_op2, o_alu_opsel, o_alu_sub,
               o_alu_unsigned, o_alu_arith
    );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin arbiter for the single shared ALU. It has two requesters.
// Each requester has a one-entry response slot. The slot loads the ALU
// result on the edge after the grant.
module alu_share_arb #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    alu_share_arb_if.slave    bus,
    output logic [CNT_W-1:0]  o_conflict_cnt
);
    logic [1:0]      w_req_valid;
    logic [1:0]      w_rsp_ready;
    logic [1:0]      w_full;
    logic [1:0]      w_elig;
    logic [1:0]      w_cand;
    logic [1:0]      w_grant;
    logic [1:0]      w_rsp_eq;
    logic [1:0]      w_rsp_lt;
    logic [XLEN-1:0] w_rsp_result [2];
    logic            w_conflict;
    logic            r_last_grant;
    logic [CNT_W-1:0] r_cnt;

    assign w_req_valid = {bus.i_req1_valid, bus.i_req0_valid};
    assign w_rsp_ready = {bus.i_rsp1_ready, bus.i_rsp0_ready};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            logic            r_full;
            logic [XLEN-1:0] r_result;
            logic            r_eq;
            logic            r_lt;

            // A full slot still accepts when it is being drained in the same cycle
            assign w_elig[gi] = !r_full || w_rsp_ready[gi];
            assign w_cand[gi] = !i_rst && w_req_valid[gi] && w_elig[gi];
            assign w_full[gi] = r_full;
            assign w_rsp_result[gi] = r_result;
            assign w_rsp_eq[gi] = r_eq;
            assign w_rsp_lt[gi] = r_lt;

            // Response slot: fill on grant, empty on drain. Data holds after drain.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_full   <= 1'b0;
                    r_result <= '0;
                    r_eq     <= 1'b0;
                    r_lt     <= 1'b0;
                end else if (w_grant[gi]) begin
                    r_full   <= 1'b1;
                    r_result <= bus.i_alu_result;
                    r_eq     <= bus.i_alu_eq;
                    r_lt     <= bus.i_alu_lt;
                end else if (w_rsp_ready[gi]) begin
                    r_full   <= 1'b0;
                end
            end
        end
    endgenerate

    // Round-robin pick: on a tie, the requester not granted last time wins
    always_comb begin
        w_grant = w_cand;
        if (w_cand == 2'b11) begin
            w_grant = r_last_grant ? 2'b01 : 2'b10;
        end
    end

    // Both requesters want the ALU and at most one of them gets it
    assign w_conflict = (&w_req_valid) && ((w_grant != 2'b00) || (w_elig == 2'b00));

    // ALU operand/control mux. The bus is driven to zero when nothing is granted.
    always_comb begin
        bus.o_alu_op1      = '0;
        bus.o_alu_op2      = '0;
        bus.o_alu_opsel    = 3'b000;
        bus.o_alu_sub      = 1'b0;
        bus.o_alu_unsigned = 1'b0;
        bus.o_alu_arith    = 1'b0;
        if (w_grant[0]) begin
            bus.o_alu_op1      = bus.i_req0_op1;
            bus.o_alu_op2      = bus.i_req0_op2;
            bus.o_alu_opsel    = bus.i_req0_opsel;
            bus.o_alu_sub      = bus.i_req0_sub;
            bus.o_alu_unsigned = bus.i_req0_unsigned;
            bus.o_alu_arith    = bus.i_req0_arith;
        end else if (w_grant[1]) begin
            bus.o_alu_op1      = bus.i_req1_op1;
            bus.o_alu_op2      = bus.i_req1_op2;
            bus.o_alu_opsel    = bus.i_req1_opsel;
            bus.o_alu_sub      = bus.i_req1_sub;
            bus.o_alu_unsigned = bus.i_req1_unsigned;
            bus.o_alu_arith    = bus.i_req1_arith;
        end
    end

    // Fairness pointer and saturating contention counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
        end else begin
            if (w_grant != 2'b00) begin
                r_last_grant <= w_grant[1];
            end
            if (w_conflict && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.o_req0_ready  = w_grant[0];
    assign bus.o_req1_ready  = w_grant[1];
    assign bus.o_rsp0_valid  = w_full[0];
    assign bus.o_rsp1_valid  = w_full[1];
    assign bus.o_rsp0_result = w_rsp_result[0];
    assign bus.o_rsp1_result = w_rsp_result[1];
    assign bus.o_rsp0_eq     = w_rsp_eq[0];
    assign bus.o_rsp1_eq     = w_rsp_eq[1];
    assign bus.o_rsp0_lt     = w_rsp_lt[0];
    assign bus.o_rsp1_lt     = w_rsp_lt[1];
    assign o_conflict_cnt    = r_cnt;
endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb. It runs a directed vector table, randomized
// traffic checked against a reference model, and a saturation run on a
// 4-bit counter instance.
module tb_alu_share_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    alu_share_arb_if #(.XLEN(32)) bus ();
    alu_share_arb_if #(.XLEN(32)) sat_bus ();
    logic [15:0] cnt;
    logic [3:0]  sat_cnt;

    alu_share_arb #(.XLEN(32), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus), .o_conflict_cnt(cnt));
    alu_share_arb #(.XLEN(32), .CNT_W(4)) dut_sat (
        .i_clk(clk), .i_rst(rst), .bus(sat_bus), .o_conflict_cnt(sat_cnt));

    // Behavioural RV32I ALU: {lt, eq, result}
    function automatic logic [33:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op, input logic sub,
                                           input logic uns, input logic arith);
        logic [31:0] r;
        logic eq, lt;
        eq = (a == b);
        lt = uns ? (a < b) : ($signed(a) < $signed(b));
        case (op)
            3'd0: r = sub ? a - b : a + b;
            3'd1: r = a << b[4:0];
            3'd2: r = {31'b0, $signed(a) < $signed(b)};
            3'd3: r = {31'b0, a < b};
            3'd4: r = a ^ b;
            3'd5: begin
                if (arith) r = $unsigned($signed(a) >>> b[4:0]);
                else       r = a >> b[4:0];
            end
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return {lt, eq, r};
    endfunction

    logic [33:0] alu_m, alu_s;
    assign alu_m = alu_fn(bus.o_alu_op1, bus.o_alu_op2, bus.o_alu_opsel,
                          bus.o_alu_sub, bus.o_alu_unsigned, bus.o_alu_arith);
    assign bus.i_alu_result = alu_m[31:0];
    assign bus.i_alu_eq     = alu_m[32];
    assign bus.i_alu_lt     = alu_m[33];
    assign alu_s = alu_fn(sat_bus.o_alu_op1, sat_bus.o_alu_op2, sat_bus.o_alu_opsel,
                          sat_bus.o_alu_sub, sat_bus.o_alu_unsigned, sat_bus.o_alu_arith);
    assign sat_bus.i_alu_result = alu_s[31:0];
    assign sat_bus.i_alu_eq     = alu_s[32];
    assign sat_bus.i_alu_lt     = alu_s[33];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        v0, v1;
        logic [31:0] a0, b0, a1, b1;
        logic        s0, s1;
        logic        rr0, rr1;
        logic        e_rdy0, e_rdy1, e_rv0, e_rv1;
        logic [31:0] e_r0, e_r1;
        int          e_cnt;
    } tv_t;

    function automatic tv_t mk(input int rs, input int v0, input int v1,
                               input int a0, input int b0, input int s0,
                               input int a1, input int b1, input int s1,
                               input int rr0, input int rr1,
                               input int er0, input int er1, input int ev0, input int ev1,
                               input int eres0, input int eres1, input int ecnt);
        tv_t t;
        t.rst = rs[0]; t.v0 = v0[0]; t.v1 = v1[0];
        t.a0 = a0; t.b0 = b0; t.s0 = s0[0];
        t.a1 = a1; t.b1 = b1; t.s1 = s1[0];
        t.rr0 = rr0[0]; t.rr1 = rr1[0];
        t.e_rdy0 = er0[0]; t.e_rdy1 = er1[0]; t.e_rv0 = ev0[0]; t.e_rv1 = ev1[0];
        t.e_r0 = eres0; t.e_r1 = eres1; t.e_cnt = ecnt;
        return t;
    endfunction

    tv_t tv [17];

    // Reference model state
    bit          m_full [2];
    logic [33:0] m_val  [2];
    int          m_last;
    int          m_cnt;

    task automatic idle_inputs();
        bus.i_req0_valid = 0; bus.i_req1_valid = 0;
        bus.i_req0_op1 = 0; bus.i_req0_op2 = 0; bus.i_req0_opsel = 0;
        bus.i_req0_sub = 0; bus.i_req0_unsigned = 0; bus.i_req0_arith = 0;
        bus.i_req1_op1 = 0; bus.i_req1_op2 = 0; bus.i_req1_opsel = 0;
        bus.i_req1_sub = 0; bus.i_req1_unsigned = 0; bus.i_req1_arith = 0;
        bus.i_rsp0_ready = 0; bus.i_rsp1_ready = 0;
    endtask

    initial begin
        idle_inputs();
        sat_bus.i_req0_valid = 0; sat_bus.i_req1_valid = 0;
        sat_bus.i_req0_op1 = 0; sat_bus.i_req0_op2 = 0; sat_bus.i_req0_opsel = 0;
        sat_bus.i_req0_sub = 0; sat_bus.i_req0_unsigned = 0; sat_bus.i_req0_arith = 0;
        sat_bus.i_req1_op1 = 0; sat_bus.i_req1_op2 = 0; sat_bus.i_req1_opsel = 0;
        sat_bus.i_req1_sub = 0; sat_bus.i_req1_unsigned = 0; sat_bus.i_req1_arith = 0;
        sat_bus.i_rsp0_ready = 0; sat_bus.i_rsp1_ready = 0;

        //            rs v0 v1  a0   b0 s0  a1   b1 s1 rr0 rr1 | rdy0 rdy1 rv0 rv1 r0  r1  cnt
        tv[0]  = mk(0, 1, 0,   5,   3, 1,   0,  0, 0, 1, 1,   1, 0, 0, 0,   0,   0, 0); // single op
        tv[1]  = mk(0, 0, 0,   0,   0, 0,   0,  0, 0, 1, 1,   0, 0, 1, 0,   2,   0, 0);
        tv[2]  = mk(0, 0, 0,   0,   0, 0,   0,  0, 0, 1, 1,   0, 0, 0, 0,   2,   0, 0);
        tv[3]  = mk(1, 0, 0,   0,   0, 0,   0,  0, 0, 1, 1,   0, 0, 0, 0,   2,   0, 0); // reset
        tv[4]  = mk(0, 1, 1,  10,   1, 0,  20,  2, 0, 1, 1,   1, 0, 0, 0,   0,   0, 0); // ties
        tv[5]  = mk(0, 1, 1, 100,   1, 0, 200, 50, 1, 1, 1,   0, 1, 1, 0,  11,   0, 1);
        tv[6]  = mk(0, 1, 1,   7,   7, 1,   1,  1, 0, 1, 1,   1, 0, 0, 1,  11, 150, 2);
        tv[7]  = mk(0, 1, 1,   3,   4, 0,   9,  4, 1, 1, 1,   0, 1, 1, 0,   0, 150, 3);
        tv[8]  = mk(0, 1, 1,   1,   1, 0,  50, 50, 0, 1, 0,   1, 0, 0, 1,   0,   5, 4); // backpressure
        tv[9]  = mk(0, 1, 1,   2,   2, 0,  50, 50, 0, 1, 0,   1, 0, 1, 1,   2,   5, 5);
        tv[10] = mk(0, 1, 1,   3,   3, 0,  50, 50, 0, 1, 0,   1, 0, 1, 1,   4,   5, 6);
        tv[11] = mk(0, 1, 0,  40,   2, 0,   0,  0, 0, 1, 0,   1, 0, 1, 1,   6,   5, 7); // drain-refill
        tv[12] = mk(0, 0, 0,   0,   0, 0,   0,  0, 0, 0, 0,   0, 0, 1, 1,  42,   5, 7);
        tv[13] = mk(0, 1, 1,   9,   9, 0,   9,  9, 0, 0, 0,   0, 0, 1, 1,  42,   5, 7); // both blocked
        tv[14] = mk(1, 1, 1,   9,   9, 0,   9,  9, 0, 0, 0,   0, 0, 1, 1,  42,   5, 8); // reset mid-flight
        tv[15] = mk(0, 1, 1,   8,   1, 1,   6,  6, 0, 1, 1,   1, 0, 0, 0,   0,   0, 0);
        tv[16] = mk(0, 0, 0,   0,   0, 0,   0,  0, 0, 1, 1,   0, 0, 1, 0,   7,   0, 1);

        // Initial reset
        repeat (2) @(posedge clk);
        #1;

        // Directed vector table
        for (int i = 0; i < 17; i++) begin
            rst = tv[i].rst;
            bus.i_req0_valid = tv[i].v0; bus.i_req1_valid = tv[i].v1;
            bus.i_req0_op1 = tv[i].a0; bus.i_req0_op2 = tv[i].b0; bus.i_req0_sub = tv[i].s0;
            bus.i_req1_op1 = tv[i].a1; bus.i_req1_op2 = tv[i].b1; bus.i_req1_sub = tv[i].s1;
            bus.i_req0_opsel = 0; bus.i_req1_opsel = 0;
            bus.i_rsp0_ready = tv[i].rr0; bus.i_rsp1_ready = tv[i].rr1;
            @(negedge clk);
            chk($sformatf("tv%0d ready0", i), 64'(bus.o_req0_ready), 64'(tv[i].e_rdy0));
            chk($sformatf("tv%0d ready1", i), 64'(bus.o_req1_ready), 64'(tv[i].e_rdy1));
            chk($sformatf("tv%0d rsp0_valid", i), 64'(bus.o_rsp0_valid), 64'(tv[i].e_rv0));
            chk($sformatf("tv%0d rsp1_valid", i), 64'(bus.o_rsp1_valid), 64'(tv[i].e_rv1));
            chk($sformatf("tv%0d rsp0_result", i), 64'(bus.o_rsp0_result), 64'(tv[i].e_r0));
            chk($sformatf("tv%0d rsp1_result", i), 64'(bus.o_rsp1_result), 64'(tv[i].e_r1));
            chk($sformatf("tv%0d conflict_cnt", i), 64'(cnt), 64'(tv[i].e_cnt));
            $display("vec %0d: rst=%0d v=%0d%0d rdy=%0d%0d rv=%0d%0d r0=%0d r1=%0d cnt=%0d",
                     i, rst, tv[i].v0, tv[i].v1, bus.o_req0_ready, bus.o_req1_ready,
                     bus.o_rsp0_valid, bus.o_rsp1_valid, bus.o_rsp0_result,
                     bus.o_rsp1_result, cnt);
            @(posedge clk);
            #1;
        end

        // Randomized traffic against the reference model
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int n = 0; n < 2; n++) begin
            m_full[n] = 0;
            m_val[n]  = '0;
        end
        m_last = 1;
        m_cnt  = 0;
        for (int c = 0; c < 400; c++) begin
            int          g;
            bit          valid [2];
            bit          rdy   [2];
            bit          cand  [2];
            logic [33:0] req_res [2];
            logic [31:0] a [2];
            logic [31:0] b [2];
            logic [2:0]  op [2];
            logic [2:0]  fl [2];
            logic [40:0] exp_bus;
            rst = ($urandom_range(0, 59) == 0);
            for (int n = 0; n < 2; n++) begin
                valid[n] = ($urandom_range(0, 9) < 7);
                rdy[n]   = ($urandom_range(0, 9) < 6);
                a[n]     = $urandom;
                b[n]     = ($urandom_range(0, 3) == 0) ? a[n] : $urandom;
                op[n]    = 3'($urandom_range(0, 7));
                fl[n]    = 3'($urandom_range(0, 7));
                req_res[n] = alu_fn(a[n], b[n], op[n], fl[n][2], fl[n][1], fl[n][0]);
            end
            bus.i_req0_valid = valid[0]; bus.i_req1_valid = valid[1];
            bus.i_rsp0_ready = rdy[0];   bus.i_rsp1_ready = rdy[1];
            bus.i_req0_op1 = a[0]; bus.i_req0_op2 = b[0]; bus.i_req0_opsel = op[0];
            {bus.i_req0_sub, bus.i_req0_unsigned, bus.i_req0_arith} = fl[0];
            bus.i_req1_op1 = a[1]; bus.i_req1_op2 = b[1]; bus.i_req1_opsel = op[1];
            {bus.i_req1_sub, bus.i_req1_unsigned, bus.i_req1_arith} = fl[1];

            // Who should win this cycle
            for (int n = 0; n < 2; n++) begin
                cand[n] = !rst && valid[n] && (!m_full[n] || rdy[n]);
            end
            if (cand[0] && cand[1]) g = (m_last == 1) ? 0 : 1;
            else if (cand[0])       g = 0;
            else if (cand[1])       g = 1;
            else                    g = -1;
            exp_bus = '0;
            if (g >= 0) exp_bus = {a[g], op[g], fl[g][2], fl[g][1], fl[g][0], 3'b000};

            @(negedge clk);
            chk("rnd ready0", 64'(bus.o_req0_ready), 64'(g == 0));
            chk("rnd ready1", 64'(bus.o_req1_ready), 64'(g == 1));
            chk("rnd alu_ctrl", 64'({bus.o_alu_op1, bus.o_alu_opsel, bus.o_alu_sub,
                                     bus.o_alu_unsigned, bus.o_alu_arith, 3'b000}),
                64'(exp_bus));
            chk("rnd alu_op2", 64'(bus.o_alu_op2), (g >= 0) ? 64'(b[g]) : 64'd0);
            chk("rnd rsp0_valid", 64'(bus.o_rsp0_valid), 64'(m_full[0]));
            chk("rnd rsp1_valid", 64'(bus.o_rsp1_valid), 64'(m_full[1]));
            chk("rnd rsp0_data", 64'({bus.o_rsp0_lt, bus.o_rsp0_eq, bus.o_rsp0_result}),
                64'(m_val[0]));
            chk("rnd rsp1_data", 64'({bus.o_rsp1_lt, bus.o_rsp1_eq, bus.o_rsp1_result}),
                64'(m_val[1]));
            chk("rnd conflict_cnt", 64'(cnt), 64'(m_cnt));
            if (g >= 0) begin
                $display("rnd %0d: grant %0d op=%0d a=%h b=%h -> %h", c, g, op[g], a[g],
                         b[g], req_res[g][31:0]);
            end
            @(posedge clk);
            if (rst) begin
                for (int n = 0; n < 2; n++) begin
                    m_full[n] = 0;
                    m_val[n]  = '0;
                end
                m_last = 1;
                m_cnt  = 0;
            end else begin
                for (int n = 0; n < 2; n++) begin
                    if (g == n) begin
                        m_full[n] = 1;
                        m_val[n]  = req_res[n];
                    end else if (m_full[n] && rdy[n]) begin
                        m_full[n] = 0;
                    end
                end
                if (g >= 0) m_last = g;
                if (valid[0] && valid[1] && m_cnt < 65535) m_cnt++;
            end
            #1;
        end

        // Counter saturation on the 4-bit instance
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sat_bus.i_req0_valid = 1; sat_bus.i_req1_valid = 1;
        sat_bus.i_rsp0_ready = 1; sat_bus.i_rsp1_ready = 1;
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            chk($sformatf("sat cnt cycle %0d", i), 64'(sat_cnt), 64'((i < 15) ? i : 15));
            $display("sat %0d: cnt=%0d", i, sat_cnt);
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
